// File: rtl/fl_ticket_sequencer.sv
// fl_ticket_sequencer
//   Merges INPUT_COUNT FrameLink streams into one output stream, forwarding
//   whole frames strictly in ticket order. The ticket sits in the SOF word of
//   each frame. A frame is forwarded only from an input whose head frame
//   carries the expected ticket. An optional timeout skips a ticket that never
//   arrives.
//
// Ports
//   CLK, RESET_N                 clock, asynchronous active-low reset
//   RX_* (per input slice)       FrameLink inputs; RX_DST_RDY_N is the ready output
//   TX_*                         FrameLink output; TX_DST_RDY_N is the ready input
//   TICKET_INIT, TICKET_LOAD     expected-ticket preload, honoured only in SEARCH
//   EXPECTED                     current expected ticket
//   SKIP                         one-cycle pulse when a ticket is skipped by timeout
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// SEARCH   | no frame selected; look for a head frame with the expected ticket
// TRANSFER | input sel is wired straight through to TX until its EOF word moves
module fl_ticket_sequencer #(
  parameter int DATA_WIDTH    = 64,
  parameter int INPUT_COUNT   = 4,
  parameter int TICKET_OFFSET = 0,
  parameter int TICKET_WIDTH  = 16,
  parameter int TIMEOUT       = 0,
  localparam int REM_WIDTH    = $clog2(DATA_WIDTH / 8),
  localparam int SEL_WIDTH    = $clog2(INPUT_COUNT),
  localparam int CNT_WIDTH    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic                             CLK,
  input  logic                             RESET_N,
  input  logic [INPUT_COUNT*DATA_WIDTH-1:0] RX_DATA,
  input  logic [INPUT_COUNT*REM_WIDTH-1:0]  RX_REM,
  input  logic [INPUT_COUNT-1:0]            RX_SOF_N,
  input  logic [INPUT_COUNT-1:0]            RX_EOF_N,
  input  logic [INPUT_COUNT-1:0]            RX_SOP_N,
  input  logic [INPUT_COUNT-1:0]            RX_EOP_N,
  input  logic [INPUT_COUNT-1:0]            RX_SRC_RDY_N,
  output logic [INPUT_COUNT-1:0]            RX_DST_RDY_N,
  output logic [DATA_WIDTH-1:0]             TX_DATA,
  output logic [REM_WIDTH-1:0]              TX_REM,
  output logic                              TX_SOF_N,
  output logic                              TX_EOF_N,
  output logic                              TX_SOP_N,
  output logic                              TX_EOP_N,
  output logic                              TX_SRC_RDY_N,
  input  logic                              TX_DST_RDY_N,
  input  logic [TICKET_WIDTH-1:0]           TICKET_INIT,
  input  logic                              TICKET_LOAD,
  output logic [TICKET_WIDTH-1:0]           EXPECTED,
  output logic                              SKIP
);

  typedef enum logic {SEARCH = 1'b0, TRANSFER = 1'b1} state_t;

  state_t               state;
  logic [SEL_WIDTH-1:0] sel;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 match_found;
  logic [SEL_WIDTH-1:0] match_idx;
  logic                 last_word;

  // Scan from the top down so the lowest matching index is the one left standing.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    for (int i = INPUT_COUNT - 1; i >= 0; i--) begin
      if (!RX_SRC_RDY_N[i] && !RX_SOF_N[i] &&
          RX_DATA[i*DATA_WIDTH + TICKET_OFFSET*8 +: TICKET_WIDTH] == EXPECTED) begin
        match_found = 1'b1;
        match_idx   = SEL_WIDTH'(i);
      end
    end
  end

  // Pure pass-through of the selected input; nothing is buffered.
  always_comb begin
    TX_DATA      = RX_DATA[sel*DATA_WIDTH +: DATA_WIDTH];
    TX_REM       = RX_REM[sel*REM_WIDTH +: REM_WIDTH];
    TX_SOF_N     = 1'b1;
    TX_EOF_N     = 1'b1;
    TX_SOP_N     = 1'b1;
    TX_EOP_N     = 1'b1;
    TX_SRC_RDY_N = 1'b1;
    RX_DST_RDY_N = '1;
    if (state == TRANSFER) begin
      TX_SOF_N          = RX_SOF_N[sel];
      TX_EOF_N          = RX_EOF_N[sel];
      TX_SOP_N          = RX_SOP_N[sel];
      TX_EOP_N          = RX_EOP_N[sel];
      TX_SRC_RDY_N      = RX_SRC_RDY_N[sel];
      RX_DST_RDY_N[sel] = TX_DST_RDY_N;
    end
  end

  assign last_word = !TX_SRC_RDY_N && !TX_DST_RDY_N && !TX_EOF_N;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= SEARCH;
      sel      <= '0;
      cnt      <= '0;
      EXPECTED <= '0;
      SKIP     <= 1'b0;
    end else begin
      SKIP <= 1'b0;
      case (state)
        SEARCH: begin
          if (TICKET_LOAD) begin
            EXPECTED <= TICKET_INIT;
            cnt      <= '0;
          end else if (match_found) begin
            sel   <= match_idx;
            state <= TRANSFER;
            cnt   <= '0;
          end else if (TIMEOUT > 0) begin
            if (cnt == CNT_WIDTH'(TIMEOUT - 1)) begin
              EXPECTED <= EXPECTED + TICKET_WIDTH'(1);
              SKIP     <= 1'b1;
              cnt      <= '0;
            end else begin
              cnt <= cnt + CNT_WIDTH'(1);
            end
          end
        end
        TRANSFER: begin
          if (last_word) begin
            EXPECTED <= EXPECTED + TICKET_WIDTH'(1);
            state    <= SEARCH;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule

// File: doc/fl_ticket_sequencer.md
Name: fl_ticket_sequencer

Overview:
- Merges INPUT_COUNT FrameLink streams into one output stream, strictly ordered by a per-frame ticket carried in each frame's first word.
- Tracks an expected-ticket counter. A whole frame is forwarded only from the input whose head frame carries the expected ticket.
- Timeout/skip mode lets the output recover from lost tickets.
- Sits after parallel processing units to restore the original frame order before the output FrameLink pipeline.

Parameters:
- DATA_WIDTH, 64: FrameLink data width of every input and of the output (bits; 16/32/64/128).
- INPUT_COUNT, 4: number of input interfaces, 2..16.
- TICKET_OFFSET, 0: byte offset of the ticket within the SOF word.
- TICKET_WIDTH, 16: ticket width in bits. Constraint: TICKET_OFFSET*8+TICKET_WIDTH <= DATA_WIDTH.
- TIMEOUT, 0: cycles without a match before the expected ticket is skipped. 0 disables skipping.

Ports:
- CLK  in  1  clock
- RESET_N  in  1  asynchronous active-low reset
- RX_DATA  in  INPUT_COUNT*DATA_WIDTH  input data; input i occupies slice i
- RX_REM  in  INPUT_COUNT*log2(DATA_WIDTH/8)  input rem
- RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N  in  INPUT_COUNT each  input framing
- RX_SRC_RDY_N  in  INPUT_COUNT  input valid
- RX_DST_RDY_N  out  INPUT_COUNT  input ready
- TX_DATA  out  DATA_WIDTH  output data
- TX_REM  out  log2(DATA_WIDTH/8)  output rem
- TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N  out  1 each  output framing
- TX_SRC_RDY_N  out  1  output valid
- TX_DST_RDY_N  in  1  output ready
- TICKET_INIT  in  TICKET_WIDTH  value loaded into the expected-ticket counter
- TICKET_LOAD  in  1  synchronous load strobe; honoured only in SEARCH
- EXPECTED  out  TICKET_WIDTH  current expected ticket
- SKIP  out  1  one-cycle pulse when a ticket is skipped by timeout

Behaviour:
- Reset, asynchronous, active-low:
  - state=SEARCH, EXPECTED=0, timeout counter=0, sel=0, SKIP=0.
  - RX_DST_RDY_N all 1, TX_SRC_RDY_N=1, TX_SOF_N/EOF_N/SOP_N/EOP_N=1.
  - Reset mid-frame aborts the transfer; the partial frame is not resumed.
- Head detection: input i presents a candidate when RX_SRC_RDY_N[i]=0 and RX_SOF_N[i]=0.
  - Its ticket is RX_DATA[i*DATA_WIDTH + TICKET_OFFSET*8 +: TICKET_WIDTH].
- SEARCH state:
  - All RX_DST_RDY_N=1; TX_SRC_RDY_N=1.
  - If any candidate ticket == EXPECTED: sel <= lowest such index, state <= TRANSFER (registered, one cycle decision latency), timeout counter cleared.
  - Duplicate matches: the lowest index wins. The others keep waiting and are never matched again unless the counter wraps.
  - Else, if TIMEOUT>0: counter increments. When counter reaches TIMEOUT-1 with no match: EXPECTED <= EXPECTED+1, SKIP=1 for one cycle, counter <= 0.
  - TICKET_LOAD=1: EXPECTED <= TICKET_INIT, counter <= 0. Load has priority over a same-cycle match or skip; no transfer starts that cycle.
- TRANSFER state:
  - TX_* = RX_*[sel] combinationally (data, rem, framing, src_rdy).
  - RX_DST_RDY_N[sel] = TX_DST_RDY_N; all other RX_DST_RDY_N=1.
  - A word is transferred when TX_SRC_RDY_N=0 and TX_DST_RDY_N=0.
  - On transfer of a word with TX_EOF_N=0: EXPECTED <= EXPECTED+1, state <= SEARCH. The next frame can begin transfer at the earliest 2 cycles later.
  - TICKET_LOAD and timeout are ignored in TRANSFER.
- Arithmetic: EXPECTED increments modulo 2^TICKET_WIDTH; all-ones wraps to 0.
- Single-word frames (SOF=EOF=0 on the same word) complete in one TRANSFER cycle.
- Backpressure: either side may stall any cycle; no data is buffered internally, and no words are lost or duplicated.
- Non-matching heads wait indefinitely; inputs never overtake one another except through ticket order.

Test Plan:
1. 4 inputs; input k sends tickets k, k+4, k+8 (3-word frames), TX always ready -> output ticket sequence 0..11, each frame contiguous, EXPECTED=12 at end.
2. Out of order: input 1 sends ticket 1 at t=0, input 0 sends ticket 0 at t=20 -> ticket 0 output first; input 1 stalls with DST_RDY_N=1 until frame 0 EOF.
3. TIMEOUT=8; ticket 2 never arrives, ticket 3 waiting on input 0 -> SKIP pulses once after 8 search cycles, EXPECTED=3, then ticket 3 forwarded.
4. TICKET_WIDTH=4; TICKET_LOAD with TICKET_INIT=14; tickets 14, 15, 0, 1 -> forwarded in that order; EXPECTED wraps 15->0.
5. Random TX_DST_RDY_N (50%) during 8-word frames -> output data identical to input, order preserved, and sel's DST_RDY_N mirrors TX.
6. RESET_N asserted mid-frame at word 3 of 6 -> all outputs return to reset values immediately, EXPECTED=0; after release a fresh ticket-0 frame transfers correctly.
